// File: rtl/e_car_controller_pkg.sv
// Shared definitions for the 4-floor elevator car sequencer: floor count,
// one-hot floor constants, FSM state encoding and a small constant helper.
package e_car_controller_pkg;

    localparam int unsigned NFLR = 4;

    localparam logic [NFLR-1:0] FLR0 = 4'b0001;
    localparam logic [NFLR-1:0] FLR1 = 4'b0010;
    localparam logic [NFLR-1:0] FLR2 = 4'b0100;
    localparam logic [NFLR-1:0] FLR3 = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_MOVE   = 3'd2,
        ST_ARRIVE = 3'd3,
        ST_DOOR   = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/e_cycle_timer.sv
// Loadable down-counter shared by the travel and door phases.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (value -> 0)
//   load      load load_val this cycle (takes priority over counting)
//   load_val  reload value
//   value     current count
//   zero      count has reached 0 (counter holds there, no wrap)
module e_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/e_car_controller.sv
// Car motion/door sequencer for the 4-floor elevator. Steps the one-hot car
// position one floor per travel period in the direction committed during
// SETTLE, opens the door at requested floors and strobes the request latch.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (car homes to floor 0)
//   bts        pending requests, one bit per floor, bit0 = ground
//   dir        direction from the direction stage (1 = up), 1-cycle latency
//   curFlr     current floor, one-hot, registered
//   flr_clr    request-clear strobe (= curFlr while the door is open)
//   door_open  door open indicator
//   moving     car travelling between floors
module e_car_controller
    import e_car_controller_pkg::*;
#(
    parameter int unsigned TRAVEL_CYC = 50,
    parameter int unsigned DOOR_CYC   = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NFLR-1:0] bts,
    input  logic            dir,
    output logic [NFLR-1:0] curFlr,
    output logic [NFLR-1:0] flr_clr,
    output logic            door_open,
    output logic            moving
);

    localparam int unsigned TW = $clog2(max_u(TRAVEL_CYC, DOOR_CYC));
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYC - 1);

    state_t          state, state_nx;
    logic            mv_dir, mv_dir_nx;
    logic [NFLR-1:0] cur_nx, clr_nx;
    logic            door_nx, mov_nx;
    logic            tmr_load, tmr_zero;
    logic [TW-1:0]   tmr_val, tmr_q;
    logic            hit, at_edge;

    assign hit     = |(bts & curFlr);
    assign at_edge = dir ? (curFlr == FLR3) : (curFlr == FLR0);

    e_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_q),
        .zero     (tmr_zero)
    );

    // State register; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mv_dir    <= 1'b0;
            curFlr    <= FLR0;
            flr_clr   <= '0;
            door_open <= 1'b0;
            moving    <= 1'b0;
        end else begin
            state     <= state_nx;
            mv_dir    <= mv_dir_nx;
            curFlr    <= cur_nx;
            flr_clr   <= clr_nx;
            door_open <= door_nx;
            moving    <= mov_nx;
        end
    end

    // Next-state and timer reload.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = TRAVEL_LD;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    state_nx = ST_DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (|bts) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (at_edge) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_MOVE;
                    tmr_load = 1'b1;
                    tmr_val  = TRAVEL_LD;
                end
            end
            ST_MOVE: begin
                if (tmr_zero) state_nx = ST_ARRIVE;
            end
            ST_ARRIVE: begin
                if (hit) begin
                    state_nx = ST_DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (|bts) begin
                    state_nx = ST_SETTLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DOOR: begin
                if (tmr_zero) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so moving/door_open
    // are high exactly while the FSM sits in MOVE/DOOR.
    always_comb begin
        mv_dir_nx = (state == ST_SETTLE) ? dir : mv_dir;
        cur_nx    = curFlr;
        if (state == ST_MOVE && tmr_zero) begin
            if (mv_dir && !curFlr[NFLR-1]) begin
                cur_nx = curFlr << 1;
            end else if (!mv_dir && !curFlr[0]) begin
                cur_nx = curFlr >> 1;
            end
        end
        mov_nx  = (state_nx == ST_MOVE);
        door_nx = (state_nx == ST_DOOR);
        clr_nx  = (state_nx == ST_DOOR) ? curFlr : '0;
    end

endmodule
